// File: rtl/quick_mem_loader_pkg.sv
// Shared constants for the quick CPU memory/loader block: FSM state encodings,
// CPU opcode nibbles and a small address range helper.
package quick_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD_LEN  = 2'd0,
        ST_LOAD_DATA = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;

    // Plain unsigned compare: addresses never wrap modulo the memory depth.
    function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned depth);
        return (32'(addr) < depth);
    endfunction

endpackage

// File: rtl/quick_mem_loader_if.sv
// CPU memory bus plus byte-stream loader handshake of the quick CPU memory.
interface quick_mem_loader_if;
    logic [7:0] cpu_addr;
    logic       cpu_rd;
    logic [7:0] cpu_rdata;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic       cpu_hold;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ld_start, ld_valid, ld_data,
        input  cpu_rdata, cpu_hold, ld_ready, ld_done
    );

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ld_start, ld_valid, ld_data,
        output cpu_rdata, cpu_hold, ld_ready, ld_done
    );
endinterface

// File: rtl/quick_mem_loader_mem_array.sv
// DEPTH x 8 flop array: one synchronous write port, one combinational read port,
// synchronous clear on reset.
module quick_mem_loader_mem_array #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Storage: reset clears every word, otherwise single-port write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/quick_mem_loader.sv
// Quick CPU program/data memory with a byte-stream loader that fills it from
// address 0 and holds the CPU off while loading.
module quick_mem_loader
    import quick_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    quick_mem_loader_if.slave  bus
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  DEPTH_CNT = 9'(DEPTH);

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [8:0]    cnt_q, cnt_d;
    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [7:0]    mem_wdata_s;
    logic [7:0]    mem_rdata_s;
    logic          ld_done_s;
    logic          run_s;
    logic          rd_hit_s;

    assign run_s    = (state_q == ST_RUN);
    assign rd_hit_s = run_s & addr_in_range(bus.cpu_addr, DEPTH);

    // FSM, length and byte-count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_LOAD_LEN;
            len_q   <= 8'h00;
            cnt_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus write-port mux; ld_start always wins over a pending byte.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ld_done_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = 8'h00;
        case (state_q)
            ST_LOAD_LEN: begin
                if (bus.ld_start) begin
                    cnt_d = 9'd0;
                end else if (bus.ld_valid) begin
                    len_d = bus.ld_data;
                    cnt_d = 9'd0;
                    if (bus.ld_data == 8'h00) begin
                        state_d   = ST_RUN;
                        ld_done_s = 1'b1;
                    end else begin
                        state_d = ST_LOAD_DATA;
                    end
                end else begin
                    state_d = ST_LOAD_LEN;
                end
            end
            ST_LOAD_DATA: begin
                if (bus.ld_start) begin
                    state_d = ST_LOAD_LEN;
                    cnt_d   = 9'd0;
                end else if (bus.ld_valid) begin
                    // Bytes past the end of memory are consumed but dropped.
                    if (cnt_q < DEPTH_CNT) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = cnt_q[AW-1:0];
                        mem_wdata_s = bus.ld_data;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == ({1'b0, len_q} - 9'd1)) begin
                        state_d   = ST_RUN;
                        ld_done_s = 1'b1;
                    end else begin
                        state_d = ST_LOAD_DATA;
                    end
                end else begin
                    state_d = ST_LOAD_DATA;
                end
            end
            ST_RUN: begin
                if (bus.ld_start) begin
                    state_d = ST_LOAD_LEN;
                    cnt_d   = 9'd0;
                end else if (bus.cpu_wr && addr_in_range(bus.cpu_addr, DEPTH)) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = bus.cpu_addr[AW-1:0];
                    mem_wdata_s = bus.cpu_wdata;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD_LEN;
                cnt_d   = 9'd0;
            end
        endcase
    end

    quick_mem_loader_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we_s),
        .waddr_i (mem_waddr_s),
        .wdata_i (mem_wdata_s),
        .raddr_i (bus.cpu_addr[AW-1:0]),
        .rdata_o (mem_rdata_s)
    );

    assign bus.cpu_hold = ~run_s;
    assign bus.ld_ready = ~run_s;
    assign bus.ld_done  = ld_done_s & ~rst_i;

    // Reads sample the array before the edge, so a same-cycle store returns the old word.
    if (READ_LATENCY == 0) begin : g_rd_comb
        assign bus.cpu_rdata = (bus.cpu_rd && rd_hit_s) ? mem_rdata_s : 8'h00;
    end else begin : g_rd_reg
        logic [7:0] rdata_q, rdata_d;

        // Capture on a read strobe, otherwise keep the last value.
        always_comb begin
            rdata_d = rdata_q;
            if (bus.cpu_rd) begin
                rdata_d = rd_hit_s ? mem_rdata_s : 8'h00;
            end else begin
                rdata_d = rdata_q;
            end
        end

        // Registered read data.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rdata_q <= 8'h00;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign bus.cpu_rdata = run_s ? rdata_q : 8'h00;
    end

endmodule
